// File: rtl/eight_one_mux.sv
// Registered 8-to-1 word mux for the ALU result bus.
// sel picks a[sel]; out updates one clk later.
module eight_one_mux #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         sel,
  input  logic [8*WIDTH-1:0] a,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_out;

  // decode sel to one of the eight packed words
  always_comb begin
    w_word = '0;
    unique case (sel)
      3'd0: w_word = a[0*WIDTH +: WIDTH];
      3'd1: w_word = a[1*WIDTH +: WIDTH];
      3'd2: w_word = a[2*WIDTH +: WIDTH];
      3'd3: w_word = a[3*WIDTH +: WIDTH];
      3'd4: w_word = a[4*WIDTH +: WIDTH];
      3'd5: w_word = a[5*WIDTH +: WIDTH];
      3'd6: w_word = a[6*WIDTH +: WIDTH];
      3'd7: w_word = a[7*WIDTH +: WIDTH];
    endcase
  end

  // register the selected word; reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_word;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_eight_one_mux.sv
// Directed bench for eight_one_mux.
// Hand-computed vectors, one check task.
module tb_eight_one_mux;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic [63:0] a;
  logic [7:0]  out;

  int n_chk;
  int n_fail;

  logic [7:0] w [8];

  eight_one_mux #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .a   (a),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string    tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 8; k++)
      a[k*8 +: 8] = w[k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_common();
    w[0] = 8'h7B; w[1] = 8'h85;
    w[2] = 8'h5B; w[3] = 8'hF6;
    w[4] = 8'h72; w[5] = 8'h1E;
    w[6] = 8'hA2; w[7] = 8'h99;
    pack();
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] walk_exp  [8];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sweep_exp = '{8'h7B, 8'h85, 8'h5B, 8'hF6,
                  8'h72, 8'h1E, 8'hA2, 8'h99};
    walk_exp  = '{8'h01, 8'h02, 8'h04, 8'h08,
                  8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1'b1;
    sel = 3'd5;
    load_common();

    // 1: reset for two edges, then release
    tick();
    check("rst_edge1", out, 8'h00);
    sel = 3'd2;
    tick();
    check("rst_edge2", out, 8'h00);
    rst = 1'b0;
    sel = 3'd0;
    tick();
    check("rst_release", out, 8'h7B);

    // 2: sweep all selects
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      check($sformatf("sweep%0d", i), out,
            sweep_exp[i]);
    end

    // hold inputs constant
    tick();
    check("hold1", out, 8'h99);
    tick();
    check("hold2", out, 8'h99);

    // 3: word change between edges
    sel = 3'd3;
    tick();
    check("w3_before", out, 8'hF6);
    w[3] = 8'h0C;
    pack();
    #2;
    check("w3_mid", out, 8'hF6);
    tick();
    check("w3_after", out, 8'h0C);
    w[3] = 8'hF6;
    pack();

    // 4: reset with sel=7 on same edge
    sel = 3'd7;
    rst = 1'b1;
    tick();
    check("rst_sel7", out, 8'h00);
    rst = 1'b0;
    tick();
    check("post_rst7", out, 8'h99);

    // 5: toggle 0/7 every cycle
    for (int i = 0; i < 6; i++) begin
      sel = (i % 2 == 0) ? 3'd0 : 3'd7;
      tick();
      check($sformatf("toggle%0d", i), out,
            (i % 2 == 0) ? 8'h7B : 8'h99);
    end

    // simultaneous sel and word change
    w[1] = 8'h3C;
    pack();
    sel = 3'd1;
    tick();
    check("sel_a_same", out, 8'h3C);

    // 6: walking one per word
    for (int k = 0; k < 8; k++)
      w[k] = walk_exp[k];
    pack();
    for (int i = 7; i >= 0; i--) begin
      sel = 3'(i);
      tick();
      check($sformatf("walk%0d", i), out,
            walk_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
